apb_timestamp_log: RTL

//  Downstream consumer of the APB ms-timer checkpoint output. Each ts_valid strobe pushes the
//  32-bit checkpoint value into a FIFO, so software can drain a trace of profiling timestamps.
//  APB slave on the same peripheral bus as the timer. Raises a level interrupt at a fill threshold.

---
 rtl/ts_log_pkg.sv | 15 +
 rtl/ts_fifo.sv | 42 ++++
 rtl/apb_timestamp_log.sv | 83 ++++++++
 3 files changed

// File: rtl/ts_log_pkg.sv
// ts_log_pkg: register offsets and STATUS/CTRL bit positions for apb_timestamp_log
package ts_log_pkg;
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_NONE   = 2'd3
    } reg_sel_e;
    localparam int ST_EMPTY    = 16;
    localparam int ST_FULL     = 17;
    localparam int ST_OVF      = 18;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_TH_LSB = 8;
endpackage

// File: rtl/ts_fifo.sv
// ts_fifo: synchronous FIFO of 2**DEPTH_LOG2 words with occupancy count
// ports: pclk/presetn, push/pop/clr controls, din/dout data, count/full/empty status
module ts_fifo #(
    parameter int W          = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr,
    input  logic [W-1:0]          din,
    output logic [W-1:0]          dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr, rptr;
    logic                    do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign dout    = mem[rptr];
    assign do_pop  = pop & ~empty;
    // a pop frees the slot, so a push into a full FIFO may proceed alongside it
    assign do_push = push & (~full | do_pop);
    always_ff @(posedge pclk)
        if (do_push) mem[wptr] <= din;
    always_ff @(posedge pclk) begin
        if (!presetn || clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/apb_timestamp_log.sv
// apb_timestamp_log: APB-readable FIFO log of timer checkpoint values with threshold irq
// ports: pclk/presetn; ts_in/ts_valid push side; irq level out; APB slave psel..pslverr
module apb_timestamp_log
    import ts_log_pkg::*;
#(
    parameter int ADDRWIDTH  = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [31:0]          ts_in,
    input  logic                 ts_valid,
    output logic                 irq,
    input  logic                 psel,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [31:0]          pwdata,
    output logic [31:0]          prdata,
    output logic                 pready,
    output logic                 pslverr
);
    reg_sel_e              sel;
    logic                  access, wr_ctrl, clear_pulse, pop, push;
    logic                  enable, overflow, full, empty;
    logic [7:0]            thresh;
    logic [31:0]           dout, status, ctrl_rd, rd_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  unused;
    assign unused      = ^{paddr[ADDRWIDTH-1:4], paddr[1:0], pwdata[31:16], pwdata[7:2]};
    assign sel         = reg_sel_e'(paddr[3:2]);
    assign access      = psel & penable;
    assign wr_ctrl     = access & pwrite & (sel == REG_CTRL);
    assign clear_pulse = wr_ctrl & pwdata[CTRL_CLR];
    assign pop         = access & ~pwrite & (sel == REG_DATA);
    assign push        = ts_valid & enable & ~clear_pulse;
    assign pready      = 1'b1;
    assign pslverr     = access & (sel == REG_NONE);
    ts_fifo #(.W(32), .DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .pclk    (pclk),
        .presetn (presetn),
        .push    (push),
        .pop     (pop),
        .clr     (clear_pulse),
        .din     (ts_in),
        .dout    (dout),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );
    always_comb begin
        status                 = '0;
        status[DEPTH_LOG2:0]   = count;
        status[ST_EMPTY]       = empty;
        status[ST_FULL]        = full;
        status[ST_OVF]         = overflow;
        ctrl_rd                = '0;
        ctrl_rd[CTRL_EN]       = enable;
        ctrl_rd[CTRL_TH_LSB+:8] = thresh;
        rd_data = sel == REG_DATA   ? (empty ? '0 : dout) :
                  sel == REG_STATUS ? status :
                  sel == REG_CTRL   ? ctrl_rd : '0;
    end
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            enable   <= 1'b0;
            thresh   <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
            prdata   <= '0;
        end else begin
            if (wr_ctrl) begin
                enable <= pwdata[CTRL_EN];
                thresh <= pwdata[CTRL_TH_LSB+:8];
            end
            // a coincident pop makes room, so only an unpaired push into a full FIFO is lost
            overflow <= clear_pulse ? 1'b0 : overflow | (push & full & ~pop);
            irq      <= enable & (thresh != '0) & (32'(count) >= 32'(thresh));
            // latched at setup so the value holds through the access phase
            if (psel && !penable) prdata <= rd_data;
        end
    end
endmodule
